// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped prescaled 32-bit timer with compare match and level interrupt
module iomem_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);
   typedef enum logic {IDLE, ACK} state_t;
   state_t      state;
   logic [2:0]  ctrl;
   logic [15:0] prescale;
   logic [15:0] pre_cnt;
   logic [31:0] count;
   logic [31:0] compare;
   logic        match;
   logic [7:0]  off;
   logic        sel;
   logic        go;
   logic        wr;
   logic        tick;
   logic        hit;
   logic [31:0] wmask;
   logic [31:0] rd_val;
   logic [31:0] merged;
   assign off    = iomem_addr[7:0];
   assign sel    = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8];
   assign go     = sel && state == IDLE && !iomem_ready;
   assign wr     = go && |iomem_wstrb;
   assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
   assign tick   = ctrl[0] && pre_cnt == prescale;
   assign hit    = tick && count == compare;
   assign irq    = match && ctrl[2];
   // the current register value doubles as the base for byte-merged writes
   assign merged = (rd_val & ~wmask) | (iomem_wdata & wmask);
   always_comb
      rd_val = off == 8'h00 ? {29'b0, ctrl} :
               off == 8'h04 ? {16'b0, prescale} :
               off == 8'h08 ? count :
               off == 8'h0C ? compare :
               off == 8'h10 ? {31'b0, match} : 32'b0;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state       <= IDLE;
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         ctrl        <= '0;
         prescale    <= '0;
         pre_cnt     <= '0;
         count       <= '0;
         compare     <= '0;
         match       <= 1'b0;
      end else begin
         state       <= go ? ACK : IDLE;
         iomem_ready <= go;
         iomem_rdata <= go ? rd_val : '0;
         if (wr && off == 8'h00) ctrl <= merged[2:0];
         if (wr && off == 8'h04) prescale <= merged[15:0];
         if (wr && off == 8'h0C) compare <= merged;
         pre_cnt <= (wr && (off == 8'h00 || off == 8'h04)) || !ctrl[0] || tick ? '0 : pre_cnt + 16'd1;
         if (wr && off == 8'h08) count <= merged;
         else if (tick) count <= hit && ctrl[1] ? '0 : count + 32'd1;
         if (hit) match <= 1'b1;
         else if (wr && off == 8'h10 && iomem_wstrb[0] && iomem_wdata[0]) match <= 1'b0;
      end
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: scoreboard bench with a register model and closed-form tick counting
module tb_iomem_timer;
   localparam logic [31:0] BASE = 32'h0300_0000;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        irq;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last = 0;
   typedef struct {bit chk; logic [31:0] val; string name;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre;
   logic [31:0] m_count, m_cmp;
   logic        m_match;

   iomem_timer #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (iomem_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_ack: got ready=1, expected no pending request");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk) check(mon_e.name, iomem_rdata, mon_e.val);
         end
      end else check("rdata_idle", iomem_rdata, 32'h0);

   function automatic logic [31:0] m_read(input logic [7:0] o);
      case (o)
         8'h00: return {29'b0, m_ctrl};
         8'h04: return {16'b0, m_pre};
         8'h08: return m_count;
         8'h0C: return m_cmp;
         8'h10: return {31'b0, m_match};
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      v = m_read(o);
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      case (o)
         8'h00: m_ctrl = v[2:0];
         8'h04: m_pre = v[15:0];
         8'h08: m_count = v;
         8'h0C: m_cmp = v;
         8'h10: if (s[0] && d[0]) m_match = 1'b0;
         default: ;
      endcase
   endtask

   // called on a falling edge; the request is captured on edge cyc+1, recorded in 'last'
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit chk, input logic [31:0] e, input string nm, input int tgt);
      bit seen;
      while (cyc + 1 < tgt) @(negedge clk);
      last = cyc + 1;
      iomem_addr = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      iomem_valid = 1'b1;
      if (a[31:8] == BASE[31:8]) begin
         sb.push_back('{chk, e, nm});
         @(negedge clk);
         check({nm, "_ack"}, 32'(iomem_ready), 32'h1);
         iomem_valid = 1'b0;
         @(negedge clk);
         check({nm, "_pulse"}, 32'(iomem_ready), 32'h0);
      end else begin
         seen = 1'b0;
         repeat (3) begin
            @(negedge clk);
            seen = seen | iomem_ready;
         end
         iomem_valid = 1'b0;
         check({nm, "_nosel"}, 32'(seen), 32'h0);
         @(negedge clk);
      end
   endtask

   task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF, input int tgt = 0);
      bus(BASE | 32'(o), d, s, 1'b0, 32'h0, "wr", tgt);
   endtask

   task automatic rd(input logic [7:0] o, input logic [31:0] e, input string nm, input int tgt = 0);
      bus(BASE | 32'(o), 32'h0, 4'h0, 1'b1, e, nm, tgt);
   endtask

   task automatic do_reset();
      #2 resetn = 1'b0;
      #1;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  off;
      logic [31:0] a, d;
      logic [3:0]  s;
      int kind, w, t, q;
      bit seen;
      @(negedge clk);
      check("rst_ready", 32'(iomem_ready), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rdata", iomem_rdata, 32'h0);
      resetn = 1'b1;
      rd(8'h0C, 32'h0, "cmp_rst");
      for (int i = 0; i < 5; i++) rd(8'(4 * i), 32'h0, "reg_rst");
      wr(8'h0C, 32'd5);
      rd(8'h0C, 32'd5, "cmp_rb");
      wr(8'h08, 32'h1122_3344);
      wr(8'h08, 32'hAABB_CCDD, 4'b0010);
      rd(8'h08, 32'h1122_CC44, "strb_merge");
      // random register traffic with the timer held off
      m_ctrl = '0; m_pre = '0; m_count = 32'h1122_CC44; m_cmp = 32'd5; m_match = 1'b0;
      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 7));
         off = kind <= 4 ? 8'(4 * kind) : 8'($urandom);
         a = kind == 6 ? (BASE ^ (32'h100 << $urandom_range(0, 23))) | 32'(off) : BASE | 32'(off);
         d = $urandom;
         s = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom);
         if (off == 8'h00) d[0] = 1'b0;
         if (s == 4'h0) bus(a, d, s, 1'b1, kind == 6 ? 32'h0 : m_read(off), "rand_rd", 0);
         else begin
            bus(a, d, s, 1'b0, 32'h0, "rand_wr", 0);
            if (kind != 6) m_write(off, d, s);
         end
      end
      do_reset();
      // auto-reload: one tick per edge, COUNT cycles 0..3
      wr(8'h08, 32'h0);
      wr(8'h04, 32'h0);
      wr(8'h0C, 32'd3);
      wr(8'h00, 32'd7);
      w = last;
      t = w;
      for (int i = 0; i < 6; i++) begin
         t = t + 2 + int'($urandom_range(0, 2));
         rd(8'h08, 32'((t - w - 1) % 4), "ar_count", t);
      end
      t = last + 2;
      rd(8'h10, 32'((t - w - 1) >= 4), "ar_match", t);
      check("irq_set", 32'(irq), 32'((cyc - w) >= 4));
      wr(8'h00, 32'd6);
      q = last;
      wr(8'h10, 32'h1);
      rd(8'h10, 32'h0, "w1c");
      check("irq_clr", 32'(irq), 32'h0);
      rd(8'h08, 32'((q - w) % 4), "frozen");
      // prescale 2 with wrap from all-ones
      wr(8'h00, 32'h0);
      wr(8'h04, 32'd2);
      wr(8'h08, 32'hFFFF_FFFF);
      wr(8'h0C, 32'd10);
      wr(8'h00, 32'd1);
      w = last;
      for (int i = 1; i <= 4; i++) rd(8'h08, 32'hFFFF_FFFF + 32'((2 * i - 1) / 3), "wrap_count", w + 2 * i);
      wr(8'h04, 32'd2, 4'hF, w + 10);
      q = last;
      rd(8'h08, 32'hFFFF_FFFF + 32'((q - w) / 3) + 32'((5) / 3), "pre_restart", q + 6);
      rd(8'h10, 32'h0, "wrap_nomatch");
      // bus write to COUNT beats a coincident tick
      wr(8'h00, 32'h0);
      wr(8'h04, 32'h0);
      wr(8'h00, 32'd1);
      wr(8'h08, 32'd100);
      q = last;
      rd(8'h08, 32'd100 + 32'(1), "cnt_coll", q + 2);
      rd(8'h08, 32'd100 + 32'(3), "cnt_coll2", q + 4);
      // W1C lands on the same edge as a match tick
      wr(8'h00, 32'h0);
      wr(8'h08, 32'h0);
      wr(8'h0C, 32'd3);
      wr(8'h10, 32'h1);
      wr(8'h00, 32'd3);
      w = last;
      wr(8'h10, 32'h1, 4'hF, w + 4);
      rd(8'h10, 32'h1, "set_wins", w + 6);
      // asynchronous reset in the middle of an acknowledge
      wr(8'h00, 32'd6);
      check("irq_ie", 32'(irq), 32'h1);
      sb.push_back('{1'b1, 32'd3, "rd_pre_rst"});
      iomem_addr = BASE | 32'h0C;
      iomem_wstrb = 4'h0;
      iomem_valid = 1'b1;
      @(negedge clk);
      check("ack_pre_rst", 32'(iomem_ready), 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("ready_async", 32'(iomem_ready), 32'h0);
      check("irq_async", 32'(irq), 32'h0);
      sb.push_back('{1'b1, 32'h0, "reack_data"});
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         seen = iomem_ready;
      end
      check("reack", 32'(seen), 32'h1);
      iomem_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) rd(8'(4 * i), 32'h0, "post_rst");
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
